// File: rtl/rfwild_pkg.sv
// Shared types and defaults for the RFWild burst gate.
package rfwild_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;
    localparam int unsigned FRM_W_DEFAULT = 8;

    // Last count of a frame for the default counter width.
    localparam int unsigned CNT_MAX = (1 << CNT_W_DEFAULT) - 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DONE
    } burst_state_t;

endpackage

// File: rtl/rfwild_window_cmp.sv
// Combinational window membership test, including windows that wrap past the
// top of the count range.
module rfwild_window_cmp #(
    parameter int unsigned CNT_W = 4
) (
    input  logic [CNT_W-1:0] c_i,
    input  logic [CNT_W-1:0] start_i,
    input  logic [CNT_W-1:0] stop_i,
    output logic             in_win_o
);

    // Straight window is an inclusive range; a wrapped one is its two tails.
    always_comb begin
        if (start_i <= stop_i) begin
            in_win_o = (c_i >= start_i) && (c_i <= stop_i);
        end else begin
            in_win_o = (c_i >= start_i) || (c_i <= stop_i);
        end
    end

endmodule

// File: rtl/rfwild_burst_gate.sv
// Burst gate: turns the free-running count into a windowed RF enable repeated
// for a programmed number of frames, and flags count discontinuities.
module rfwild_burst_gate
    import rfwild_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned FRM_W = FRM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] contador,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_start,
    input  logic [CNT_W-1:0] cfg_stop,
    input  logic [FRM_W-1:0] cfg_frames,
    input  logic             go,
    input  logic             abort,
    output logic             rf_en,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             busy,
    output logic             done,
    output logic             seq_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    burst_state_t     state_q, state_d;
    logic [CNT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] stop_q, stop_d;
    logic [FRM_W-1:0] frames_q, frames_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             rf_en_q, rf_en_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;

    logic             in_win;
    logic             in_burst;
    logic [CNT_W-1:0] prev_inc;

    rfwild_window_cmp #(
        .CNT_W (CNT_W)
    ) u_window (
        .c_i      (contador),
        .start_i  (start_q),
        .stop_i   (stop_q),
        .in_win_o (in_win)
    );

    assign in_burst = (state_q == ARMED) || (state_q == ACTIVE);
    assign prev_inc = prev_q + 1'b1;

    // Next-state, config latch, frame counting, sequence check and enable.
    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        stop_d       = stop_q;
        frames_d     = frames_q;
        frame_cnt_d  = frame_cnt_q;
        seq_err_d    = seq_err_q;
        prev_d       = prev_q;
        prev_valid_d = 1'b0;
        rf_en_d      = 1'b0;

        if (cfg_valid && cfg_ready_q) begin
            start_d     = cfg_start;
            stop_d      = cfg_stop;
            frames_d    = cfg_frames;
            frame_cnt_d = '0;
            seq_err_d   = 1'b0;
        end

        if (in_burst) begin
            prev_d       = contador;
            prev_valid_d = 1'b1;
            if (prev_valid_q && (contador != prev_inc)) begin
                seq_err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d     = ARMED;
                    frame_cnt_d = '0;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (contador == '0) begin
                    state_d = ACTIVE;
                    rf_en_d = in_win;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rf_en_d = in_win;
                    if (contador == CNT_LAST) begin
                        if (frame_cnt_q != '1) begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                        if ((frames_q != '0) && (frame_cnt_d == frames_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cfg_ready_d = (state_d == IDLE) || (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            start_q      <= '0;
            stop_q       <= '0;
            frames_q     <= FRM_W'(1);
            frame_cnt_q  <= '0;
            rf_en_q      <= 1'b0;
            cfg_ready_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            frames_q     <= frames_d;
            frame_cnt_q  <= frame_cnt_d;
            rf_en_q      <= rf_en_d;
            cfg_ready_q  <= cfg_ready_d;
            seq_err_q    <= seq_err_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign rf_en     = rf_en_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = in_burst;
    assign done      = (state_q == DONE);
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_rfwild_burst_gate.sv
// Self-checking bench for rfwild_burst_gate: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_rfwild_burst_gate;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] contador;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_start;
    logic [3:0] cfg_stop;
    logic [7:0] cfg_frames;
    logic       go;
    logic       abort;
    logic       rf_en;
    logic [7:0] frame_cnt;
    logic       busy;
    logic       done;
    logic       seq_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: activity flags, window as a membership map.
    bit m_wait, m_run, m_fin;
    bit m_ready, m_rf, m_err, m_prev_ok;
    int m_prev, m_fc, m_start, m_stop, m_frames;
    bit [15:0] win_map;

    rfwild_burst_gate #(
        .CNT_W (4),
        .FRM_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .contador   (contador),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_frames (cfg_frames),
        .go         (go),
        .abort      (abort),
        .rf_en      (rf_en),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .done       (done),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk from start forward (mod 16) to stop, marking every visited count.
    task automatic build_map();
        int k;
        win_map = '0;
        k = m_start;
        for (int n = 0; n < 16; n++) begin
            win_map[k] = 1'b1;
            if (k == m_stop) break;
            k = (k + 1) % 16;
        end
    endtask

    task automatic model_edge();
        int c;
        bit in_use, live, nrf;
        c = int'(contador);
        if (!reset) begin
            m_wait = 0; m_run = 0; m_fin = 0;
            m_ready = 0; m_rf = 0; m_err = 0; m_prev_ok = 0; m_prev = 0;
            m_fc = 0; m_start = 0; m_stop = 0; m_frames = 1;
            build_map();
            return;
        end
        in_use = m_wait || m_run;
        nrf = 0;
        if (in_use) begin
            if (m_prev_ok && c != (m_prev + 1) % 16) m_err = 1;
            m_prev_ok = 1;
            m_prev = c;
        end else begin
            m_prev_ok = 0;
        end
        if (cfg_valid && m_ready) begin
            m_start = int'(cfg_start);
            m_stop = int'(cfg_stop);
            m_frames = int'(cfg_frames);
            m_fc = 0;
            m_err = 0;
            build_map();
        end
        if (!in_use) begin
            if (go) begin
                m_wait = 1; m_fin = 0; m_fc = 0;
            end
        end else if (abort) begin
            m_wait = 0; m_run = 0;
        end else begin
            live = m_run || (m_wait && c == 0);
            if (live) begin
                m_wait = 0; m_run = 1;
                nrf = win_map[c];
                if (c == 15) begin
                    if (m_fc < 255) m_fc++;
                    if (m_frames != 0 && m_fc == m_frames) begin
                        m_run = 0; m_fin = 1;
                    end
                end
            end
        end
        m_rf = nrf;
        m_ready = !(m_wait || m_run);
    endtask

    // One clock: update the model from the inputs seen at the edge, compare
    // just after it, then drop single-cycle requests and advance the count.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rf_en", {31'b0, rf_en}, {31'b0, m_rf});
        chk("frame_cnt", {24'b0, frame_cnt}, 32'(m_fc));
        chk("busy", {31'b0, busy}, {31'b0, (m_wait || m_run)});
        chk("done", {31'b0, done}, {31'b0, m_fin});
        chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, m_ready});
        chk("seq_err", {31'b0, seq_err}, {31'b0, m_err});
        go = 0;
        abort = 0;
        cfg_valid = 0;
        contador = contador + 4'd1;
    endtask

    task automatic offer_cfg(input int s, input int e, input int f, input bit with_go);
        cfg_valid = 1;
        cfg_start = 4'(s);
        cfg_stop = 4'(e);
        cfg_frames = 8'(f);
        go = with_go;
    endtask

    initial begin
        int pulses;
        int hold;
        reset = 0; contador = 0; cfg_valid = 0; cfg_start = 0; cfg_stop = 0;
        cfg_frames = 0; go = 0; abort = 0;

        // Reset and release
        step();
        step();
        chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
        chk("rst_rf_en", {31'b0, rf_en}, 32'd0);
        reset = 1;
        step();
        chk("rel_cfg_ready", {31'b0, cfg_ready}, 32'd1);

        // Straight window 3..6, two frames
        offer_cfg(3, 6, 2, 0);
        step();
        go = 1;
        step();
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (rf_en) pulses++;
            if (done) break;
        end
        chk("t1_pulses", 32'(pulses), 32'd8);
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_frames", {24'b0, frame_cnt}, 32'd2);
        chk("t1_ready", {31'b0, cfg_ready}, 32'd1);

        // Wrapped window 14..1, one frame
        offer_cfg(14, 1, 1, 1);
        step();
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (rf_en) pulses++;
            if (done) break;
        end
        chk("t2_pulses", 32'(pulses), 32'd4);
        chk("t2_done", {31'b0, done}, 32'd1);

        // Continuous single-count pulse, then abort
        offer_cfg(0, 0, 0, 1);
        step();
        for (int i = 0; i < 40; i++) begin
            step();
            if (rf_en) break;
        end
        chk("t3_first", {31'b0, rf_en}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (rf_en) pulses++;
        end
        chk("t3_pulses", 32'(pulses), 32'd4);
        chk("t3_busy", {31'b0, busy}, 32'd1);
        hold = int'(frame_cnt);
        abort = 1;
        step();
        chk("t3_abort_rf", {31'b0, rf_en}, 32'd0);
        chk("t3_abort_busy", {31'b0, busy}, 32'd0);
        chk("t3_abort_fc", {24'b0, frame_cnt}, 32'(hold));

        // Config and go together from IDLE; config offered mid-burst ignored
        offer_cfg(8, 9, 3, 1);
        step();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rf_en) begin pulses++; break; end
        end
        chk("t5_active_ready", {31'b0, cfg_ready}, 32'd0);
        offer_cfg(0, 15, 1, 0);
        for (int i = 0; i < 80; i++) begin
            step();
            if (rf_en) pulses++;
            if (done) break;
        end
        chk("t5_pulses", 32'(pulses), 32'd6);
        chk("t5_frames", {24'b0, frame_cnt}, 32'd3);

        // Skipped count while ARMED
        contador = 3;
        offer_cfg(2, 4, 1, 1);
        step();
        step();
        step();
        contador = contador + 4'd1;
        step();
        chk("t4_err_set", {31'b0, seq_err}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) break;
        end
        chk("t4_err_done", {31'b0, seq_err}, 32'd1);
        chk("t4_done", {31'b0, done}, 32'd1);
        offer_cfg(2, 4, 1, 0);
        step();
        chk("t4_err_clr", {31'b0, seq_err}, 32'd0);

        // Reset in the middle of an active window
        offer_cfg(0, 15, 0, 1);
        step();
        for (int i = 0; i < 40; i++) begin
            step();
            if (rf_en) break;
        end
        chk("t6_pre_rf", {31'b0, rf_en}, 32'd1);
        reset = 0;
        step();
        chk("t6_rf", {31'b0, rf_en}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_ready", {31'b0, cfg_ready}, 32'd0);
        reset = 1;
        step();
        chk("t6_rel_ready", {31'b0, cfg_ready}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0)
                offer_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), 0);
            go = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) contador = contador + 4'($urandom_range(1, 14));
            step();
        end
        reset = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
